// File: rtl/sram_pkg.sv
// Shared constants and helpers for the banked GF180 SRAM wrapper.
package sram_pkg;
    localparam int BANK_AW     = 9;
    localparam int MACRO_DW    = 32;
    localparam int MACRO_DEPTH = 512;
    localparam int MACRO_NWM   = MACRO_DW / 8;

    // Wide enough for the largest supported bank count (8).
    typedef logic [2:0] bank_idx_t;

    function automatic bank_idx_t bank_of(input logic [31:0] addr, input int nb);
        return bank_idx_t'((addr >> BANK_AW) & 32'(nb - 1));
    endfunction
endpackage

// File: rtl/gf180_ram_512x32.sv
// Behavioural model of the GF180 512x32 single-port macro (active-low CEN/GWEN/WEN).
// Power pins are present only when USE_POWER_PINS is defined.
module GF180_RAM_512x32 (
`ifdef USE_POWER_PINS
    inout  wire         VDD,
    inout  wire         VSS,
`endif
    input  logic        CLK,
    input  logic        CEN,
    input  logic        GWEN,
    input  logic [31:0] WEN,
    input  logic [8:0]  A,
    input  logic [31:0] D,
    output logic [31:0] Q
);
    logic [31:0] mem [512];

    // Q only changes on a read; writes leave the previous read data in place.
    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            else       Q      <= mem[A];
        end
    end
endmodule

// File: rtl/sram_bank.sv
// One 512x32 bank: wraps the macro, expands byte masks into per-bit active-low WEN.
// Power pins are passed through when USE_POWER_PINS is defined.
module sram_bank
    import sram_pkg::*;
(
`ifdef USE_POWER_PINS
    inout  wire                  VDD,
    inout  wire                  VSS,
`endif
    input  logic                 clk_i,
    input  logic                 cen_i,
    input  logic                 gwen_i,
    input  logic [MACRO_NWM-1:0] wmask_i,
    input  logic [BANK_AW-1:0]   a_i,
    input  logic [MACRO_DW-1:0]  d_i,
    output logic [MACRO_DW-1:0]  q_o
);
    logic [MACRO_DW-1:0] wen;

    always_comb begin
        wen = '1;
        for (int i = 0; i < MACRO_NWM; i++) wen[i*8 +: 8] = {8{~wmask_i[i]}};
    end

    GF180_RAM_512x32 u_macro (
`ifdef USE_POWER_PINS
        .VDD  (VDD),
        .VSS  (VSS),
`endif
        .CLK  (clk_i),
        .CEN  (cen_i),
        .GWEN (gwen_i),
        .WEN  (wen),
        .A    (a_i),
        .D    (d_i),
        .Q    (q_o)
    );
endmodule

// File: rtl/sram_banked_2p.sv
// NUM_BANKS x 512x32 macros tiled into one memory with a RW port 0 and a RO port 1.
// Optional SRAM_STATS_EN adds a saturating port-1 conflict counter; USE_POWER_PINS adds VDD/VSS.
module sram_banked_2p
    import sram_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int STARVE_LIM = 4,
    parameter int ADDR_WIDTH = BANK_AW + $clog2(NUM_BANKS),
    parameter int DATA_WIDTH = MACRO_DW,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
`ifdef USE_POWER_PINS
    inout  wire                   VDD,
    inout  wire                   VSS,
`endif
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  csb0_i,
    input  logic                  web0_i,
    input  logic [NUM_WMASKS-1:0] wmask0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] din0_i,
    output logic                  ready0_o,
    output logic [DATA_WIDTH-1:0] dout0_o,
    output logic                  rvalid0_o,
    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    output logic                  gnt1_o,
    output logic [DATA_WIDTH-1:0] dout1_o,
`ifdef SRAM_STATS_EN
    input  logic                  stat_clr_i,
    output logic [15:0]           conflict_cnt_o,
`endif
    output logic                  rvalid1_o
);
    localparam int BIW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int SCW = $clog2(STARVE_LIM + 1);

    logic [BIW-1:0] bank0, bank1, rbank0_q, rbank1_q;
    logic           collide, force1, acc0, acc1;
    logic [SCW-1:0] starve_q, starve_d;
    logic           rd0_q, rd1_q;
    logic [DATA_WIDTH-1:0] cap0_q, cap1_q;
    logic [NUM_BANKS-1:0]  sel0, sel1;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] q;

    assign bank0 = BIW'(bank_of(32'(addr0_i), NUM_BANKS));
    assign bank1 = BIW'(bank_of(32'(addr1_i), NUM_BANKS));

    // Port 0 wins bank collisions until port 1 has been turned away STARVE_LIM times in a row.
    assign collide  = !csb0_i && req1_i && (bank0 == bank1);
    assign force1   = collide && (starve_q == SCW'(STARVE_LIM));
    assign ready0_o = !force1;
    assign gnt1_o   = resetn_i && req1_i && (!collide || force1);
    assign acc0     = resetn_i && !csb0_i && ready0_o;
    assign acc1     = gnt1_o;

    always_comb begin
        starve_d = starve_q;
        if (gnt1_o)       starve_d = '0;
        else if (collide) starve_d = starve_q + 1'b1;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign sel0[b] = acc0 && (bank0 == BIW'(b));
        assign sel1[b] = acc1 && (bank1 == BIW'(b));

        sram_bank u_bank (
`ifdef USE_POWER_PINS
            .VDD     (VDD),
            .VSS     (VSS),
`endif
            .clk_i   (clk_i),
            .cen_i   (~(sel0[b] | sel1[b])),
            .gwen_i  (sel0[b] ? web0_i : 1'b1),
            .wmask_i (wmask0_i),
            .a_i     (sel0[b] ? addr0_i[BANK_AW-1:0] : addr1_i[BANK_AW-1:0]),
            .d_i     (din0_i),
            .q_o     (q[b])
        );
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            starve_q <= '0;
            rd0_q    <= 1'b0;
            rd1_q    <= 1'b0;
            rbank0_q <= '0;
            rbank1_q <= '0;
            cap0_q   <= '0;
            cap1_q   <= '0;
        end else begin
            starve_q <= starve_d;
            rd0_q    <= acc0 && web0_i;
            rd1_q    <= acc1;
            rbank0_q <= bank0;
            rbank1_q <= bank1;
            // Capture so outputs survive the other port later reusing the bank.
            if (rd0_q) cap0_q <= q[rbank0_q];
            if (rd1_q) cap1_q <= q[rbank1_q];
        end
    end

    assign rvalid0_o = rd0_q;
    assign rvalid1_o = rd1_q;
    assign dout0_o   = rd0_q ? q[rbank0_q] : cap0_q;
    assign dout1_o   = rd1_q ? q[rbank1_q] : cap1_q;

`ifdef SRAM_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i)                                       conflict_q <= '0;
        else if (stat_clr_i)                                 conflict_q <= '0;
        else if (req1_i && !gnt1_o && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
    end

    assign conflict_cnt_o = conflict_q;
`endif
endmodule

// File: tb/tb_sram_banked_2p.sv
// Randomized scoreboard bench for sram_banked_2p (default 2 banks, 1024 words).
module tb_sram_banked_2p;
    localparam int NB = 2;
    localparam int AW = 10;
    localparam int NW = NB * 512;

    logic          clk = 1'b0;
    logic          resetn;
    logic          csb0, web0, req1;
    logic [3:0]    wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   din0, dout0, dout1;
    logic          ready0, rvalid0, gnt1, rvalid1;
`ifdef SRAM_STATS_EN
    logic          stat_clr;
    logic [15:0]   conflict_cnt;
`endif

    always #5 clk = ~clk;

    sram_banked_2p #(.NUM_BANKS(NB)) dut (
        .clk_i     (clk),
        .resetn_i  (resetn),
        .csb0_i    (csb0),
        .web0_i    (web0),
        .wmask0_i  (wmask0),
        .addr0_i   (addr0),
        .din0_i    (din0),
        .ready0_o  (ready0),
        .dout0_o   (dout0),
        .rvalid0_o (rvalid0),
        .req1_i    (req1),
        .addr1_i   (addr1),
        .gnt1_o    (gnt1),
        .dout1_o   (dout1),
`ifdef SRAM_STATS_EN
        .stat_clr_i     (stat_clr),
        .conflict_cnt_o (conflict_cnt),
`endif
        .rvalid1_o (rvalid1)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [NW];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] last0, last1;
    int          denials;
    int          stat_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // One clock of stimulus; the reference decides acceptance from the arbitration rules
    // and predicts read data from its own memory image.
    task automatic cycle(input bit p0, input bit we, input logic [3:0] wm, input int a0,
                         input logic [31:0] d0, input bit r1, input int a1,
                         output bit dut_g1, output bit exp_g1);
        bit col, frc, er0, eg1;
        @(negedge clk);
        csb0 = !p0; web0 = !we; wmask0 = wm; addr0 = AW'(a0); din0 = d0;
        req1 = r1; addr1 = AW'(a1);
        col = p0 && r1 && (a0 / 512 == a1 / 512);
        frc = col && (denials == 4);
        er0 = !frc;
        eg1 = r1 && (!col || frc);
        #1;
        chk("ready0", 32'(ready0), 32'(er0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        dut_g1 = gnt1;
        exp_g1 = eg1;
        if (eg1) q1.push_back(mem[a1]);
        if (p0 && er0) begin
            if (we) begin
                for (int i = 0; i < 4; i++) if (wm[i]) mem[a0][i*8 +: 8] = d0[i*8 +: 8];
            end else begin
                q0.push_back(mem[a0]);
            end
        end
        if (eg1)      denials = 0;
        else if (col) denials++;
`ifdef SRAM_STATS_EN
        if (stat_clr)              stat_m = 0;
        else if (r1 && !eg1 && stat_m < 65535) stat_m++;
`endif
    endtask

    task automatic idle();
        bit g, e;
        cycle(0, 0, 4'h0, 0, 32'h0, 0, 0, g, e);
    endtask

    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        if (resetn) begin
            if (rvalid0) begin
                if (q0.size() == 0) flag("rvalid0 unexpected");
                else begin e = q0.pop_front(); chk("dout0", dout0, e); last0 = e; end
            end else begin
                if (q0.size() != 0) begin flag("rvalid0 missing"); void'(q0.pop_front()); end
                chk("dout0_hold", dout0, last0);
            end
            if (rvalid1) begin
                if (q1.size() == 0) flag("rvalid1 unexpected");
                else begin e = q1.pop_front(); chk("dout1", dout1, e); last1 = e; end
            end else begin
                if (q1.size() != 0) begin flag("rvalid1 missing"); void'(q1.pop_front()); end
                chk("dout1_hold", dout1, last1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g, e, pend, r1;
        int pa1;
        resetn = 1'b0; csb0 = 1'b0; web0 = 1'b1; wmask0 = 4'h0; addr0 = '0; din0 = '0;
        req1 = 1'b1; addr1 = '0;
        last0 = '0; last1 = '0; denials = 0; stat_m = 0;
`ifdef SRAM_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        @(negedge clk);
        csb0 = 1'b1; req1 = 1'b0;
        resetn = 1'b1;
        #1 chk("rst_ready0", 32'(ready0), 32'd1);

        for (int a = 0; a < NW; a++) cycle(1, 1, 4'hF, a, $urandom, 0, 0, g, e);

        // Full write, read, byte-masked merge, read.
        cycle(1, 1, 4'hF, 'h005, 32'hDEADBEEF, 0, 0, g, e);
        cycle(1, 0, 4'h0, 'h005, 32'h0, 0, 0, g, e);
        cycle(1, 1, 4'b0010, 'h005, 32'h0000AA00, 0, 0, g, e);
        cycle(1, 0, 4'h0, 'h005, 32'h0, 0, 0, g, e);
        idle();
        chk("merge_read", dout0, 32'hDEADAAEF);

        // Different banks in the same cycle.
        cycle(1, 0, 4'h0, 'h010, 32'h0, 1, 'h210, g, e);
        chk("parallel_gnt1", 32'(g), 32'd1);
        idle();

        // Same-bank collision: port 1 forced through every fifth cycle.
        for (int i = 0; i < 15; i++) begin
            cycle(1, 0, 4'h0, $urandom_range(0, 511), 32'h0, 1, 'h020, g, e);
            chk("starve_gnt1", 32'(g), 32'(i % 5 == 4));
        end
        idle();

        // Port 1 data survives port 0 reusing the bank.
        cycle(1, 1, 4'hF, 'h030, 32'h00001234, 0, 0, g, e);
        cycle(0, 0, 4'h0, 0, 32'h0, 1, 'h030, g, e);
        cycle(1, 0, 4'h0, 'h031, 32'h0, 0, 0, g, e);
        cycle(1, 0, 4'h0, 'h032, 32'h0, 0, 0, g, e);
        idle();
        chk("hold_dout1", dout1, 32'h00001234);

        // Reset while read data is being returned.
        cycle(1, 0, 4'h0, 'h005, 32'h0, 1, 'h205, g, e);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_rvalid0", 32'(rvalid0), 32'd0);
        chk("midrst_rvalid1", 32'(rvalid1), 32'd0);
        chk("midrst_dout0", dout0, 32'h0);
        chk("midrst_dout1", dout1, 32'h0);
        chk("midrst_gnt1", 32'(gnt1), 32'd0);
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0; denials = 0; stat_m = 0;
        csb0 = 1'b1; req1 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        pend = 1'b0; pa1 = 0; r1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend) begin
                r1  = ($urandom % 2) == 1;
                pa1 = $urandom_range(0, NW - 1);
            end
            cycle(($urandom % 4) != 0, ($urandom % 3) == 0, 4'($urandom),
                  $urandom_range(0, NW - 1), $urandom, r1, pa1, g, e);
            pend = r1 && !e;
        end
        idle();

`ifdef SRAM_STATS_EN
        #1 chk("conflict_cnt", 32'(conflict_cnt), 32'(stat_m));
        stat_clr = 1'b1;
        cycle(1, 0, 4'h0, 'h001, 32'h0, 1, 'h002, g, e);
        stat_clr = 1'b0;
        idle();
        chk("conflict_clr", 32'(conflict_cnt), 32'(stat_m));
        chk("conflict_clr0", 32'(conflict_cnt), 32'd0);
`endif
        idle();
        idle();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
